// File: rtl/sel_decoder5_to_32_pkg.sv
// Shared types and widths for the 5-to-32 select decoder block.
// Imported by the decoder sub-module and the sequencing top.
package sel_decoder5_to_32_pkg;

  localparam int CODE_W = 5;
  localparam int SEL_W  = 32;
  localparam int LEN_W  = 3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    GAP   = 2'd2
  } state_t;

endpackage

// File: rtl/sel_decoder5_to_32_decoder.sv
// Pure combinational 5-bit code to 32-bit one-hot decoder.
module decoder5_to_32
  import sel_decoder5_to_32_pkg::*;
(
  input  logic [CODE_W-1:0] code,
  output logic [SEL_W-1:0]  onehot
);

  // NOTE: every output of an always_comb gets a default before any branch,
  // otherwise unassigned paths infer latches.
  always_comb begin
    onehot       = '0;
    onehot[code] = 1'b1;
  end

endmodule

// File: rtl/sel_decoder5_to_32.sv
// Grants one select line for a latched number of cycles, then enforces
// GAP_CYCLES dead cycles before the next request can be accepted.
module sel_decoder5_to_32
  import sel_decoder5_to_32_pkg::*;
#(
  parameter int GAP_CYCLES = 1
) (
  input  logic              clk,
  input  logic              clr,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [CODE_W-1:0] req_code,
  input  logic [LEN_W-1:0]  req_len,
  output logic [SEL_W-1:0]  sel,
  output logic              busy,
  output logic              done
);

  state_t             state, state_next;
  logic [LEN_W-1:0]   cnt, cnt_next;
  logic [SEL_W-1:0]   sel_next, dec_sel;
  logic               done_next;
  logic               accept;

  decoder5_to_32 u_dec (
    .code   (req_code),
    .onehot (dec_sel)
  );

  assign req_ready = (state == IDLE);
  assign accept    = req_valid && req_ready;

  // cnt counts remaining DRIVE cycles, then is reused for remaining GAP cycles.
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    sel_next   = sel;
    done_next  = 1'b0;
    case (state)
      IDLE: begin
        if (accept) begin
          state_next = DRIVE;
          sel_next   = dec_sel;
          cnt_next   = (req_len == '0) ? LEN_W'(1) : req_len;
        end
      end
      DRIVE: begin
        if (cnt == LEN_W'(1)) begin
          sel_next  = '0;
          done_next = 1'b1;
          if (GAP_CYCLES > 0) begin
            state_next = GAP;
            cnt_next   = LEN_W'(GAP_CYCLES);
          end else begin
            state_next = IDLE;
            cnt_next   = '0;
          end
        end else begin
          cnt_next = cnt - LEN_W'(1);
        end
      end
      GAP: begin
        if (cnt == LEN_W'(1)) begin
          state_next = IDLE;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt - LEN_W'(1);
        end
      end
      default: begin
        state_next = IDLE;
        sel_next   = '0;
        cnt_next   = '0;
      end
    endcase
  end

  // NOTE: clr is sampled on the clock edge only and overrides acceptance,
  // so a request arriving with clr is simply dropped.
  // NOTE: non-blocking assignments here so every register loads from
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (clr) begin
      state <= IDLE;
      cnt   <= '0;
      sel   <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
      sel   <= sel_next;
      busy  <= (state_next != IDLE);
      done  <= done_next;
    end
  end

endmodule

// File: doc/sel_decoder5_to_32.md
SEL_DECODER5_TO_32 -- requirements
Module: sel_decoder5_to_32

Interface
REQ-001 SHALL have parameter GAP_CYCLES, default 1, meaning the number of dead cycles with sel all-zero after each grant (legal 0..3).
REQ-002 SHALL have port clk, input, 1, the single rising-edge clock.
REQ-003 SHALL have port clr, input, 1, synchronous active-high reset.
REQ-004 SHALL have port req_valid, input, 1, request present.
REQ-005 SHALL have port req_ready, output, 1, block can accept a request this cycle.
REQ-006 SHALL have port req_code, input, 5, index of the select line to assert (0..31).
REQ-007 SHALL have port req_len, input, 3, number of drive cycles, with 0 treated as 1.
REQ-008 SHALL have port sel, output, 32, registered one-hot select, all-zero when not driving.
REQ-009 SHALL have port busy, output, 1, high in any state other than IDLE.
REQ-010 SHALL have port done, output, 1, single-cycle pulse marking grant completion.

Function
REQ-011 SHALL implement states IDLE, DRIVE and GAP.
REQ-012 SHALL drive req_ready high only in IDLE.
REQ-013 SHALL accept a request on a rising edge where req_valid and req_ready are both high, latching req_code and max(req_len,1) into the drive counter.
REQ-014 SHALL enter DRIVE on the edge of acceptance, so sel = 1 << code is visible in the first cycle after acceptance (latency 1).
REQ-015 SHALL hold sel constant and exactly one-hot for the latched drive count of consecutive cycles in DRIVE.
REQ-016 SHALL leave DRIVE after its last cycle and go to GAP if GAP_CYCLES > 0, otherwise to IDLE.
REQ-017 SHALL hold sel = 0 for exactly GAP_CYCLES cycles in GAP, then return to IDLE.
REQ-018 SHALL pulse done high for exactly one cycle: the first cycle after the last DRIVE cycle, whether that cycle is GAP or IDLE.
REQ-019 SHALL ignore req_valid, req_code and req_len while req_ready is low; inputs are not sampled outside IDLE.
REQ-020 SHALL never assert more than one sel bit in any cycle, including across back-to-back grants.
REQ-021 SHALL give a minimum request-to-request period of 1 + len + GAP_CYCLES cycles.
REQ-022 SHALL keep busy registered and consistent with state: busy = (state != IDLE).

Reset
REQ-023 SHALL, on clr high at a rising edge, set state=IDLE, sel=0, busy=0, done=0, clear the counter, and return req_ready=1 in the following cycle.
REQ-024 SHALL make clr take priority over acceptance; a request coincident with clr is dropped.
REQ-025 SHALL, on clr mid-DRIVE or mid-GAP, deassert sel the next cycle with no done pulse.

Structure
REQ-026 SHALL place the state enumeration, CODE_W=5 and SEL_W=32 constants in the shared CPU package.
REQ-027 SHALL instantiate one combinational sub-module, decoder5_to_32, mapping a 5-bit code to a 32-bit one-hot word, with the registered sel fed from it.

Verification
REQ-028 SHALL check code=7, len=1, GAP=1 accepted at edge T -> sel=32'h00000080 in cycle T+1 only; done at T+2; req_ready high again at T+3.
REQ-029 SHALL check code=31, len=0 -> exactly one cycle of sel=32'h80000000 (zero length treated as one).
REQ-030 SHALL check code=0, len=5, GAP=0 -> sel=32'h00000001 for 5 cycles, done and req_ready together on the following cycle, and back-to-back code=1 accepted with no idle gap beyond IDLE.
REQ-031 SHALL check that req_valid with code=3 held continuously during a code=12, len=4 grant is not accepted until IDLE, and that sel never shows two bits.
REQ-032 SHALL check clr asserted in the 2nd DRIVE cycle of a len=4 grant -> sel=0 next cycle, no done, and req_ready=1.
REQ-033 SHALL run a randomized sweep of all 32 codes with len 0..7 and GAP 0..3, checking $onehot0(sel) every cycle and one done per accepted request.
